store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
// - Store-side counterpart of the register file's load writeback: takes rs2 data (register file read port b) plus address and width for SB/SH/SW.
// - Aligns the data to byte lanes and generates byte enables.
// - Queues stores in a small FIFO and drains them to data memory over a valid/ready handshake, so the core does not stall on memory.
// - Gives the load path an address-hit check so loads can stall behind pending stores to the same word.
// PARAMETERS
// - DEPTH  4   FIFO entries; power of 2, >=2
// PORTS
// - clk              in   1   single clock, rising edge
// - rst_n            in   1   asynchronous, active-low reset
// - req_valid        in   1   store request from core
// - req_ready        out  1   buffer can accept (= !full)
// - req_address      in   32  byte address
// - req_data         in   32  rs2 value, unaligned (LSBs significant)
// - req_pattern      in   2   STORE_BYTE=0, STORE_HALF=1, STORE_WORD=2; 3 illegal
// - mem_valid        out  1   head entry presented to data memory
// - mem_ready        in   1   memory accepts head entry
// - mem_address      out  32  word address {addr[31:2],2'b00}
// - mem_data         out  32  lane-aligned data
// - mem_byte_enable  out  4   lane enables, bit i = byte i
// - misaligned       out  1   1-cycle pulse: rejected request
// - lookup_address   in   32  load address from load path
// - lookup_hit       out  1   combinational: a valid entry has the same word address
// - empty            out  1   no entries pending
// - count            out  clog2(DEPTH+1)  entries pending
// BEHAVIOUR
// - Reset (rst_n=0, async): pointers and count cleared; all entries invalid.
//   - Reset values: mem_valid=0, mem_address=0, mem_data=0, mem_byte_enable=0, misaligned=0, empty=1, count=0, req_ready=1.
//   - Reset mid-operation discards all pending stores; no partial write is issued.
// - Accept: req_valid & req_ready at a rising edge. When full, req_ready=0 and there is no fall-through.
// - Alignment check:
//   - Half with addr[0]=1, word with addr[1:0]!=0, or pattern 3 is rejected.
//   - A rejected request still completes the handshake, is not enqueued, and sets misaligned=1 for exactly the next cycle.
// - Lane mapping (o = addr[1:0]):
//   - byte: data = {4{d[7:0]}},  be = 4'b0001 << o
//   - half: data = {2{d[15:0]}}, be = 4'b0011 << o
//   - word: data = d,            be = 4'hF
// - Drain: the head is registered; mem_* reflects the head entry.
//   - Latency: a store accepted at edge N into an empty buffer drives mem_valid=1 after edge N.
//   - Pop on mem_valid & mem_ready. mem_address, mem_data and mem_byte_enable stay stable while mem_valid & !mem_ready.
// - Order: strict FIFO; no merging, no reordering.
// - Simultaneous push and pop: count unchanged; with count=1 the new entry becomes the head after the edge.
// - Full: count==DEPTH. A pop frees the slot, and req_ready rises only after that edge.
// - Empty: mem_valid=0; mem_* data outputs hold their last value.
// - Pointers wrap modulo DEPTH; count saturates by construction and never exceeds DEPTH.
// - lookup_hit:
//   - Compares lookup_address[31:2] against all valid entries, including the head.
//   - A head being popped in the current cycle still counts as a hit.
// STRUCTURE
// - rtl/parameters.vh: STORE_BYTE/STORE_HALF/STORE_WORD codes next to the REGISTER_WRITE_* codes.
// - Sub-module store_lane_align: combinational mapping (address, pattern, data) -> (data, byte_enable, misaligned).
// - store_buffer holds the FIFO, pointers, count and lookup compare.
// TESTING
// - Reset mid-operation: DEPTH=4 with 3 queued, assert rst_n=0 -> mem_valid=0, count=0, empty=1 immediately; no mem handshake follows.
// - SB: addr 0x103, data 0xAABBCCDD -> mem_address 0x100, mem_data 0xDDDDDDDD, be 4'b1000, mem_valid next cycle.
// - SH/SW: SH addr 0x202, data 0x1234 -> be 4'b1100, mem_data 0x12341234; SW addr 0x300 -> be 4'hF.
// - Misaligned: SH addr 0x201, SW addr 0x302 -> misaligned 1-cycle pulse each, count unchanged, no mem_valid.
// - Backpressure: mem_ready=0, push 4 stores -> req_ready=0 at count=4; the 5th req_valid is held.
//   Then mem_ready=1 -> the 4 stores drain in order, one per cycle; mem_* stable while stalled.
// - Lookup: queue SW 0x400, then lookup_address 0x402 -> lookup_hit=1; lookup_address 0x404 -> 0; after drain, 0x402 -> 0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// ============================================================================
// Module : store_buffer_pkg
// Brief  : Store pattern codes and queue entry type shared by the store buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package store_buffer_pkg;

    localparam logic [1:0] STORE_BYTE = 2'd0;
    localparam logic [1:0] STORE_HALF = 2'd1;
    localparam logic [1:0] STORE_WORD = 2'd2;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] data;
        logic [3:0]  byte_enable;
    } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_buffer_if.sv
// ============================================================================
// Module : store_buffer_if
// Brief  : Core-side store request and memory-side drain handshakes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface store_buffer_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic [1:0]  req_pattern;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic [3:0]  mem_byte_enable;

    // The buffer itself: accepts requests, drives the memory channel.
    modport slave (
        input  req_valid, req_address, req_data, req_pattern, mem_ready,
        output req_ready, mem_valid, mem_address, mem_data, mem_byte_enable
    );

    // The core / memory environment around the buffer.
    modport master (
        output req_valid, req_address, req_data, req_pattern, mem_ready,
        input  req_ready, mem_valid, mem_address, mem_data, mem_byte_enable
    );

endinterface

`default_nettype wire

// File: rtl/store_buffer_lane_align.sv
// ============================================================================
// Module : store_lane_align
// Brief  : Maps (address, pattern, rs2 data) onto byte lanes and enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_lane_align (
    input  wire logic [1:0]  offset_i,
    input  wire logic [1:0]  pattern_i,
    input  wire logic [31:0] data_i,
    output logic      [31:0] data_o,
    output logic      [3:0]  byte_enable_o,
    output logic             misaligned_o
);
    import store_buffer_pkg::*;

    always_comb begin
        data_o        = data_i;
        byte_enable_o = 4'h0;
        misaligned_o  = 1'b0;
        unique case (pattern_i)
            STORE_BYTE: begin
                data_o        = {4{data_i[7:0]}};
                byte_enable_o = 4'b0001 << offset_i;
            end
            STORE_HALF: begin
                data_o        = {2{data_i[15:0]}};
                byte_enable_o = 4'b0011 << offset_i;
                misaligned_o  = offset_i[0];
            end
            STORE_WORD: begin
                byte_enable_o = 4'hF;
                misaligned_o  = (offset_i != 2'b00);
            end
            default: begin
                misaligned_o  = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module : store_buffer
// Brief  : Store FIFO between core and data memory with load-side word lookup.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    store_buffer_if.slave                   bus,
    input  wire logic [31:0]                lookup_address,
    output logic                            lookup_hit,
    output logic                            misaligned,
    output logic                            empty,
    output logic [$clog2(DEPTH+1)-1:0]      count
);
    import store_buffer_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    sb_entry_t         entries_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     remaining;

    logic              mem_valid_q;
    sb_entry_t         head_q, head_d;
    logic              misaligned_q;

    logic [31:0]       al_data;
    logic [3:0]        al_be;
    logic              al_mis;
    logic              accept, push, pop;
    sb_entry_t         new_entry;

    store_lane_align u_align (
        .offset_i      (bus.req_address[1:0]),
        .pattern_i     (bus.req_pattern),
        .data_i        (bus.req_data),
        .data_o        (al_data),
        .byte_enable_o (al_be),
        .misaligned_o  (al_mis)
    );

    assign bus.req_ready = (count_q != C_FULL);
    assign accept        = bus.req_valid & bus.req_ready;
    assign push          = accept & ~al_mis;
    assign pop           = mem_valid_q & bus.mem_ready;

    assign new_entry.word_addr   = bus.req_address[31:2];
    assign new_entry.data        = al_data;
    assign new_entry.byte_enable = al_be;

    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign wr_ptr_d  = wr_ptr_q + PW'(push);
    assign rd_ptr_d  = rd_ptr_q + PW'(pop);
    assign remaining = count_q - CW'(pop);

    // Next head: an older entry if one survives this edge, otherwise the
    // incoming store; with nothing left the outputs keep their last value.
    always_comb begin
        head_d = head_q;
        if (remaining != '0) begin
            head_d = entries_q[rd_ptr_d];
        end else if (push) begin
            head_d = new_entry;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_valid_q  <= 1'b0;
            head_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_valid_q  <= (count_d != '0);
            head_q       <= head_d;
            misaligned_q <= accept & al_mis;
        end
    end

    // The head stays valid until its pop edge, so a load racing the drain
    // still sees the hit and stalls one more cycle.
    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entries_q[i].word_addr == lookup_address[31:2])) begin
                lookup_hit = 1'b1;
            end
        end
    end

    logic unused_lookup_lsbs;
    assign unused_lookup_lsbs = ^lookup_address[1:0];

    assign bus.mem_valid       = mem_valid_q;
    assign bus.mem_address     = {head_q.word_addr, 2'b00};
    assign bus.mem_data        = head_q.data;
    assign bus.mem_byte_enable = head_q.byte_enable;
    assign misaligned          = misaligned_q;
    assign empty               = (count_q == '0);
    assign count               = count_q;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module : tb_store_buffer
// Brief  : Scoreboard bench for store_buffer with directed and random stores.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] lookup_address;
    logic        lookup_hit;
    logic        misaligned;
    logic        empty;
    logic [2:0]  count;

    store_buffer_if sb_if ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (sb_if.slave),
        .lookup_address (lookup_address),
        .lookup_hit     (lookup_hit),
        .misaligned     (misaligned),
        .empty          (empty),
        .count          (count)
    );

    int   checks   = 0;
    int   failures = 0;
    bit   run_checks = 0;

    exp_t        sb_q [$];
    logic [29:0] model_q [$];
    bit          exp_mis;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference store semantics: lanes from arithmetic on offset and size.
    function automatic void ref_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] p, output bit mis,
                                      output logic [31:0] md, output logic [3:0] be);
        int o;
        o   = int'(a[1:0]);
        mis = (p == 2'd3) || (p == 2'd1 && (o % 2) != 0) || (p == 2'd2 && o != 0);
        case (p)
            2'd0:    begin md = (d & 32'h0000_00FF) * 32'h0101_0101; be = 4'(1 << o); end
            2'd1:    begin md = (d & 32'h0000_FFFF) * 32'h0001_0001; be = 4'(3 << o); end
            default: begin md = d; be = 4'hF; end
        endcase
    endfunction

    function automatic bit model_hit(input logic [31:0] la);
        foreach (model_q[i]) if (model_q[i] == la[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: update pending stores on every accepted edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            sb_q.delete();
            exp_mis = 1'b0;
        end else begin
            bit          acc, mis;
            logic [31:0] md;
            logic [3:0]  be;
            exp_t        e;
            acc = sb_if.req_valid && (model_q.size() < DEPTH);
            if (model_q.size() > 0 && sb_if.mem_ready) void'(model_q.pop_front());
            exp_mis = 1'b0;
            if (acc) begin
                ref_store(sb_if.req_address, sb_if.req_data, sb_if.req_pattern, mis, md, be);
                if (mis) begin
                    exp_mis = 1'b1;
                end else begin
                    model_q.push_back(sb_if.req_address[31:2]);
                    e.addr = {sb_if.req_address[31:2], 2'b00};
                    e.data = md;
                    e.be   = be;
                    sb_q.push_back(e);
                end
            end
        end
    end

    // Monitor: compares status every cycle and the presented head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && run_checks) begin
            check("req_ready", 32'(sb_if.req_ready), 32'(model_q.size() < DEPTH));
            check("count", 32'(count), 32'(model_q.size()));
            check("empty", 32'(empty), 32'(model_q.size() == 0));
            check("mem_valid", 32'(sb_if.mem_valid), 32'(model_q.size() != 0));
            check("misaligned", 32'(misaligned), 32'(exp_mis));
            check("lookup_hit", 32'(lookup_hit), 32'(model_hit(lookup_address)));
            if (sb_if.mem_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_mem_valid", 32'(1), 32'(0));
                end else begin
                    check("mem_address", sb_if.mem_address, sb_q[0].addr);
                    check("mem_data", sb_if.mem_data, sb_q[0].data);
                    check("mem_byte_enable", 32'(sb_if.mem_byte_enable), 32'(sb_q[0].be));
                    if (sb_if.mem_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        for (int n = 0; n <= 64; n++) begin
            @(negedge clk);
            if (sb_if.req_ready) break;
            if (n == 64) check("accept_timeout", 32'(0), 32'(1));
        end
        @(posedge clk);
        #1;
        sb_if.req_valid = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] p);
        sb_if.req_valid   = 1'b1;
        sb_if.req_address = a;
        sb_if.req_data    = d;
        sb_if.req_pattern = p;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] p);
        drive(a, d, p);
        wait_accept();
    endtask

    initial begin
        rst_n             = 1'b0;
        sb_if.req_valid   = 1'b0;
        sb_if.req_address = '0;
        sb_if.req_data    = '0;
        sb_if.req_pattern = '0;
        sb_if.mem_ready   = 1'b0;
        lookup_address    = '0;
        #2;
        check("rst_mem_valid", 32'(sb_if.mem_valid), 32'(0));
        check("rst_mem_address", sb_if.mem_address, 32'h0);
        check("rst_mem_data", sb_if.mem_data, 32'h0);
        check("rst_mem_be", 32'(sb_if.mem_byte_enable), 32'(0));
        check("rst_misaligned", 32'(misaligned), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_count", 32'(count), 32'(0));
        check("rst_req_ready", 32'(sb_if.req_ready), 32'(1));
        @(posedge clk); @(posedge clk); #1;
        rst_n      = 1'b1;
        run_checks = 1'b1;

        // SB to the top byte lane, held at the memory port.
        send(32'h0000_0103, 32'hAABB_CCDD, 2'd0);
        check("sb_mem_valid", 32'(sb_if.mem_valid), 32'(1));
        check("sb_mem_address", sb_if.mem_address, 32'h0000_0100);
        check("sb_mem_data", sb_if.mem_data, 32'hDDDD_DDDD);
        check("sb_mem_be", 32'(sb_if.mem_byte_enable), 32'(4'b1000));
        sb_if.mem_ready = 1'b1;
        idle(3);

        // SH upper half and SW, drained with one idle cycle in between.
        sb_if.mem_ready = 1'b0;
        send(32'h0000_0202, 32'h0000_1234, 2'd1);
        check("sh_mem_data", sb_if.mem_data, 32'h1234_1234);
        check("sh_mem_be", 32'(sb_if.mem_byte_enable), 32'(4'b1100));
        sb_if.mem_ready = 1'b1;
        idle(2);
        send(32'h0000_0300, 32'hCAFE_F00D, 2'd2);
        check("sw_mem_be", 32'(sb_if.mem_byte_enable), 32'(4'hF));
        idle(3);

        // Misaligned half and word: pulse, nothing enqueued.
        send(32'h0000_0201, 32'h1111_2222, 2'd1);
        check("mis_sh_pulse", 32'(misaligned), 32'(1));
        check("mis_sh_count", 32'(count), 32'(0));
        send(32'h0000_0302, 32'h3333_4444, 2'd2);
        check("mis_sw_pulse", 32'(misaligned), 32'(1));
        send(32'h0000_0304, 32'h5555_6666, 2'd3);
        check("mis_p3_pulse", 32'(misaligned), 32'(1));
        idle(1);
        check("mis_pulse_end", 32'(misaligned), 32'(0));
        idle(2);

        // Backpressure: fill, hold a fifth request, then drain in order.
        sb_if.mem_ready = 1'b0;
        send(32'h0000_0500, 32'h0102_0304, 2'd2);
        send(32'h0000_0505, 32'h0000_00A5, 2'd0);
        send(32'h0000_050A, 32'h0000_BEEF, 2'd1);
        send(32'h0000_050C, 32'hDEAD_BEEF, 2'd2);
        drive(32'h0000_0510, 32'h7777_8888, 2'd2);
        idle(4);
        check("full_req_ready", 32'(sb_if.req_ready), 32'(0));
        check("full_count", 32'(count), 32'(DEPTH));
        sb_if.mem_ready = 1'b1;
        wait_accept();
        idle(8);
        check("drained_empty", 32'(empty), 32'(1));

        // Lookup against a queued word, a neighbour word, and after drain.
        sb_if.mem_ready = 1'b0;
        send(32'h0000_0400, 32'h0BAD_F00D, 2'd2);
        lookup_address = 32'h0000_0402;
        #1 check("lookup_same_word", 32'(lookup_hit), 32'(1));
        lookup_address = 32'h0000_0404;
        #1 check("lookup_next_word", 32'(lookup_hit), 32'(0));
        sb_if.mem_ready = 1'b1;
        idle(3);
        lookup_address = 32'h0000_0402;
        #1 check("lookup_after_drain", 32'(lookup_hit), 32'(0));

        // Reset with three stores queued discards them.
        sb_if.mem_ready = 1'b0;
        send(32'h0000_0600, 32'h1, 2'd2);
        send(32'h0000_0604, 32'h2, 2'd2);
        send(32'h0000_0608, 32'h3, 2'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_valid", 32'(sb_if.mem_valid), 32'(0));
        check("midrst_count", 32'(count), 32'(0));
        check("midrst_empty", 32'(empty), 32'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_if.mem_ready = 1'b1;
        idle(5);

        // Random traffic with frequent word collisions for the lookup.
        for (int c = 0; c < 400; c++) begin
            sb_if.mem_ready   = ($urandom_range(0, 9) < 7);
            sb_if.req_valid   = ($urandom_range(0, 1) == 1);
            sb_if.req_address = 32'h0000_1000 + 32'($urandom_range(0, 31));
            sb_if.req_data    = $urandom;
            sb_if.req_pattern = (($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
            if (model_q.size() > 0 && $urandom_range(0, 1) == 1)
                lookup_address = {model_q[$urandom_range(0, model_q.size() - 1)], 2'($urandom_range(0, 3))};
            else
                lookup_address = 32'h0000_1000 + 32'($urandom_range(0, 31));
            idle(1);
        end
        sb_if.req_valid = 1'b0;
        sb_if.mem_ready = 1'b1;
        idle(10);
        check("final_empty", 32'(empty), 32'(1));
        check("final_scoreboard", 32'(sb_q.size()), 32'(0));

        run_checks = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
